// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The slave modport is the loader's view; the master modport is the stream source / memory side.
interface imem_loader_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) ();
    logic              byte_valid_i;
    logic [7:0]        byte_i;
    logic              byte_ready_o;
    logic              mem_we_o;
    logic [AWIDTH-1:0] mem_addr_o;
    logic [DWIDTH-1:0] mem_wdata_o;

    modport slave (
        input  byte_valid_i,
        input  byte_i,
        output byte_ready_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o
    );

    modport master (
        output byte_valid_i,
        output byte_i,
        input  byte_ready_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction loader: packs a little-endian byte stream into 32-bit words,
// writes them from BASE_ADDR upward and holds the core in reset until a session completes.
module imem_loader #(
    parameter int                AWIDTH    = 32,
    parameter int                DWIDTH    = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h0100_0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_i,
    input  logic [15:0]         len_i,
    imem_loader_if.slave        bus,
    output logic                busy_o,
    output logic                done_o,
    output logic                core_reset_o,
    output logic [7:0]          chk_o
);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [15:0]       len_q;
    logic [15:0]       word_cnt;
    logic [1:0]        byte_cnt;
    logic [23:0]       word_buf;
    logic [AWIDTH-1:0] addr_q;
    logic [AWIDTH-1:0] mem_addr_q;
    logic [DWIDTH-1:0] mem_wdata_q;
    logic [7:0]        chk_q;
    logic              loaded;
    logic              accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) state_next = (len_i != 16'd0) ? RECV : DONE;
            end
            RECV: begin
                accept = bus.byte_valid_i;
                if (bus.byte_valid_i && byte_cnt == 2'd3) state_next = WRITE;
            end
            WRITE: begin
                state_next = (word_cnt + 16'd1 == len_q) ? DONE : RECV;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The write port registers are loaded with the 4th byte so they present the
    // finished word during WRITE and keep showing it until the next word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q       <= 16'd0;
            word_cnt    <= 16'd0;
            byte_cnt    <= 2'd0;
            word_buf    <= 24'd0;
            addr_q      <= BASE_ADDR;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= '0;
            chk_q       <= 8'd0;
            loaded      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        chk_q <= 8'd0;
                        if (len_i != 16'd0) begin
                            len_q    <= len_i;
                            addr_q   <= BASE_ADDR;
                            byte_cnt <= 2'd0;
                            word_cnt <= 16'd0;
                        end
                    end
                end
                RECV: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        chk_q    <= chk_q ^ bus.byte_i;
                        case (byte_cnt)
                            2'd0: word_buf[7:0]   <= bus.byte_i;
                            2'd1: word_buf[15:8]  <= bus.byte_i;
                            2'd2: word_buf[23:16] <= bus.byte_i;
                            default: begin
                                mem_addr_q  <= addr_q;
                                mem_wdata_q <= {bus.byte_i, word_buf};
                            end
                        endcase
                    end
                end
                WRITE: begin
                    addr_q   <= addr_q + AWIDTH'(4);
                    word_cnt <= word_cnt + 16'd1;
                end
                DONE: begin
                    loaded <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.byte_ready_o = (state == RECV);
    assign bus.mem_we_o     = (state == WRITE);
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.mem_wdata_o  = mem_wdata_q;
    assign busy_o           = (state == RECV) || (state == WRITE);
    assign done_o           = (state == DONE);
    assign core_reset_o     = !loaded || (state != IDLE);
    assign chk_o            = chk_q;

endmodule

// File: tb/tb_imem_loader.sv
// Drives two loaders (normal base and wrapping base) with the same byte stream and
// scoreboards their memory writes against a word-level model of the stream.
module tb_imem_loader;

    localparam logic [31:0] BASE0 = 32'h0100_0000;
    localparam logic [31:0] BASE1 = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_i = 1'b0;
    logic [15:0] len_i = 16'd0;
    logic        busy0, done0, crst0;
    logic        busy1, done1, crst1;
    logic [7:0]  chk0, chk1;

    imem_loader_if #(.AWIDTH(32), .DWIDTH(32)) bus0 ();
    imem_loader_if #(.AWIDTH(32), .DWIDTH(32)) bus1 ();

    always #5 clk = ~clk;

    imem_loader #(.AWIDTH(32), .DWIDTH(32), .BASE_ADDR(BASE0)) dut0 (
        .clk(clk), .reset(reset), .start_i(start_i), .len_i(len_i), .bus(bus0),
        .busy_o(busy0), .done_o(done0), .core_reset_o(crst0), .chk_o(chk0)
    );

    imem_loader #(.AWIDTH(32), .DWIDTH(32), .BASE_ADDR(BASE1)) dut1 (
        .clk(clk), .reset(reset), .start_i(start_i), .len_i(len_i), .bus(bus1),
        .busy_o(busy1), .done_o(done1), .core_reset_o(crst1), .chk_o(chk1)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] expAddr0[$];
    logic [31:0] expData0[$];
    logic [31:0] expAddr1[$];
    logic [31:0] expData1[$];
    logic [7:0]  lanes[$];
    logic [7:0]  chkModel;
    int          wordIdx;
    logic        donePrev = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the oldest word the model produced
    always @(negedge clk) begin
        if (reset) begin
            if (bus0.mem_we_o) begin
                if (expAddr0.size() == 0) checkOutput("dut0 unexpected write", bus0.mem_addr_o, 32'hDEAD_BEEF);
                else begin
                    checkOutput("dut0 write addr", bus0.mem_addr_o, expAddr0.pop_front());
                    checkOutput("dut0 write data", bus0.mem_wdata_o, expData0.pop_front());
                end
            end
            if (bus1.mem_we_o) begin
                if (expAddr1.size() == 0) checkOutput("dut1 unexpected write", bus1.mem_addr_o, 32'hDEAD_BEEF);
                else begin
                    checkOutput("dut1 write addr", bus1.mem_addr_o, expAddr1.pop_front());
                    checkOutput("dut1 write data", bus1.mem_wdata_o, expData1.pop_front());
                end
            end
            if (done0) checkOutput("done single cycle", 32'(donePrev), 32'd0);
            donePrev = done0;
        end else begin
            donePrev = 1'b0;
        end
    end

    task automatic setValid(input logic v, input logic [7:0] b);
        start_i           = 1'b0;
        bus0.byte_valid_i = v;
        bus1.byte_valid_i = v;
        bus0.byte_i       = b;
        bus1.byte_i       = b;
    endtask

    task automatic startSession(input int len);
        @(negedge clk);
        start_i  = 1'b1;
        len_i    = 16'(len);
        chkModel = 8'd0;
        wordIdx  = 0;
        lanes.delete();
        @(negedge clk);
        start_i = 1'b0;
        len_i   = 16'($urandom);
    endtask

    task automatic sendByte(input logic [7:0] b, input int gaps, input bit poke);
        int guard;
        repeat (gaps) begin
            @(negedge clk);
            setValid(1'b0, 8'($urandom));
        end
        @(negedge clk);
        setValid(1'b1, b);
        if (poke) begin
            start_i = 1'b1;
            len_i   = 16'd5;
        end
        guard = 0;
        while (!bus0.byte_ready_o && guard < 50) begin
            @(negedge clk);
            start_i = 1'b0;
            guard++;
        end
        if (guard >= 50) checkOutput("ready timeout", 32'd0, 32'd1);
        // The byte is taken on the coming rising edge: fold it into the model now
        chkModel ^= b;
        lanes.push_back(b);
        if (lanes.size() == 4) begin
            expAddr0.push_back(BASE0 + 32'(4 * wordIdx));
            expAddr1.push_back(BASE1 + 32'(4 * wordIdx));
            expData0.push_back({lanes[3], lanes[2], lanes[1], lanes[0]});
            expData1.push_back({lanes[3], lanes[2], lanes[1], lanes[0]});
            wordIdx++;
            lanes.delete();
        end
    endtask

    task automatic applyStimulus(input int len, input logic [7:0] data[$], input int gapMin,
                                 input int gapMax, input int pokeIdx);
        startSession(len);
        for (int i = 0; i < data.size(); i++)
            sendByte(data[i], int'($urandom_range(gapMax, gapMin)), i == pokeIdx);
    endtask

    task automatic waitDone();
        int guard;
        @(negedge clk);
        setValid(1'b0, 8'h00);
        guard = 0;
        while (!done0 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("done0 seen", 32'(done0), 32'd1);
        checkOutput("done1 in step", 32'(done1), 32'd1);
        checkOutput("busy in DONE", 32'(busy0), 32'd0);
        checkOutput("core_reset in DONE", 32'(crst0), 32'd1);
        @(negedge clk);
        checkOutput("done0 dropped", 32'(done0), 32'd0);
        checkOutput("busy after DONE", 32'(busy0), 32'd0);
        checkOutput("core_reset0 released", 32'(crst0), 32'd0);
        checkOutput("core_reset1 released", 32'(crst1), 32'd0);
        checkOutput("chk0", 32'(chk0), 32'(chkModel));
        checkOutput("chk1", 32'(chk1), 32'(chkModel));
        checkOutput("dut0 writes drained", expAddr0.size(), 32'd0);
        checkOutput("dut1 writes drained", expAddr1.size(), 32'd0);
    endtask

    task automatic checkReset();
        checkOutput("rst ready0", 32'(bus0.byte_ready_o), 32'd0);
        checkOutput("rst we0", 32'(bus0.mem_we_o), 32'd0);
        checkOutput("rst addr0", bus0.mem_addr_o, BASE0);
        checkOutput("rst addr1", bus1.mem_addr_o, BASE1);
        checkOutput("rst wdata0", bus0.mem_wdata_o, 32'd0);
        checkOutput("rst busy0", 32'(busy0), 32'd0);
        checkOutput("rst done0", 32'(done0), 32'd0);
        checkOutput("rst chk0", 32'(chk0), 32'd0);
        checkOutput("rst core_reset0", 32'(crst0), 32'd1);
        checkOutput("rst core_reset1", 32'(crst1), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] stream[$];
        logic [7:0] rnd[$];
        int         len;

        setValid(1'b0, 8'h00);
        repeat (3) @(negedge clk);
        checkReset();
        reset = 1'b1;
        @(negedge clk);
        checkOutput("core_reset before load", 32'(crst0), 32'd1);

        $display("[TB] two-word program, valid held high");
        stream = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        applyStimulus(2, stream, 0, 0, -1);
        waitDone();
        checkOutput("chk literal", 32'(chk0), 32'h90);

        $display("[TB] same program, valid toggling");
        applyStimulus(2, stream, 1, 1, -1);
        waitDone();

        $display("[TB] zero-length session");
        @(negedge clk);
        start_i = 1'b1;
        len_i   = 16'd0;
        @(negedge clk);
        start_i = 1'b0;
        checkOutput("len0 done", 32'(done0), 32'd1);
        checkOutput("len0 busy", 32'(busy0), 32'd0);
        @(negedge clk);
        checkOutput("len0 done dropped", 32'(done0), 32'd0);
        checkOutput("len0 chk cleared", 32'(chk0), 32'd0);

        $display("[TB] start during RECV ignored");
        applyStimulus(2, stream, 0, 1, 1);
        waitDone();
        repeat (3) @(negedge clk);
        checkOutput("no restart", 32'(busy0), 32'd0);

        $display("[TB] random sessions");
        for (int s = 0; s < 6; s++) begin
            len = int'($urandom_range(5, 1));
            rnd.delete();
            for (int i = 0; i < 4 * len; i++) rnd.push_back(8'($urandom));
            applyStimulus(len, rnd, 0, 2, -1);
            waitDone();
        end

        $display("[TB] reset mid-word");
        startSession(3);
        sendByte(8'hAA, 0, 1'b0);
        sendByte(8'h55, 0, 1'b0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 checkReset();
        lanes.delete();
        @(negedge clk);
        setValid(1'b0, 8'h00);
        reset = 1'b1;
        stream = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        applyStimulus(1, stream, 0, 1, -1);
        waitDone();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter AWIDTH, default 32, address width.
REQ-002 Parameter DWIDTH, default 32, instruction word width; only 32 is supported.
REQ-003 Parameter BASE_ADDR, default 32'h0100_0000, address of the first loaded word (core reset PC).
REQ-004 Port `clk`, input, 1, single clock; all state changes on its rising edge.
REQ-005 Port `reset`, input, 1, reset; asynchronous, active-low.
REQ-006 Port `start_i`, input, 1, request to begin a load session.
REQ-007 Port `len_i`, input, 16, number of words to load; sampled only when a start is accepted.
REQ-008 Port `byte_valid_i`, input, 1, a byte is offered on the input stream.
REQ-009 Port `byte_i`, input, 8, stream byte.
REQ-010 Port `byte_ready_o`, output, 1, the loader accepts a byte this cycle.
REQ-011 Port `mem_we_o`, output, 1, instruction-memory write strobe.
REQ-012 Port `mem_addr_o`, output, AWIDTH, write address.
REQ-013 Port `mem_wdata_o`, output, DWIDTH, write data.
REQ-014 Port `busy_o`, output, 1, a session is in progress.
REQ-015 Port `done_o`, output, 1, one-cycle end-of-session pulse.
REQ-016 Port `core_reset_o`, output, 1, holds fetch/decode in reset.
REQ-017 Port `chk_o`, output, 8, XOR of all bytes accepted in the current or last session.

Function
REQ-018 The FSM SHALL have states IDLE, RECV, WRITE and DONE.
REQ-019 IDLE behaviour:
- `start_i`=1 and `len_i`≠0: latch the length, set address to BASE_ADDR, clear byte count, word count and `chk_o`, then go to RECV.
- `start_i`=1 and `len_i`=0: clear `chk_o` and go to DONE with no memory writes.
REQ-020 `start_i` SHALL be ignored in every state other than IDLE.
REQ-021 In RECV, `byte_ready_o`=1; in all other states, `byte_ready_o`=0.
REQ-022 Each byte is accepted only when `byte_valid_i`=1 and `byte_ready_o`=1. On acceptance:
- the byte goes into lane byte_cnt of the word buffer (little-endian: the first byte is bits [7:0]);
- byte_cnt increments;
- `chk_o` ^= byte.
REQ-023 When the 4th byte of a word is accepted, the FSM SHALL go to WRITE in the next cycle; byte_cnt wraps to 0.
REQ-024 In WRITE, for exactly one cycle:
- `mem_we_o`=1, `mem_addr_o`=current address, `mem_wdata_o`=assembled word;
- then address += 4 (wraps modulo 2^AWIDTH) and word count increments;
- next state is DONE if word count equals the latched length, otherwise RECV.
REQ-025 `mem_we_o` SHALL be 0 outside WRITE; `mem_addr_o`/`mem_wdata_o` SHALL hold their last values outside WRITE.
REQ-026 In DONE, `done_o`=1 for exactly one cycle, then the FSM goes to IDLE; `done_o`=0 in all other states.
REQ-027 `busy_o` SHALL be 1 in RECV and WRITE, and 0 in IDLE and DONE.
REQ-028 Internal flag `loaded` SHALL be set in DONE and cleared only by reset. `core_reset_o` = !loaded OR (state≠IDLE).
REQ-029 Throughput: at most one word per 5 cycles (4 accept cycles + 1 WRITE).
REQ-030 A 65535-word session SHALL complete without counter overflow; the word counter is 16 bits.

Reset
REQ-031 Asserting `reset` (low) in any state, including mid-word or mid-WRITE, SHALL immediately put the block in IDLE. Partial words are discarded and not written.
REQ-032 Reset values:
- `byte_ready_o`=0, `mem_we_o`=0, `mem_addr_o`=BASE_ADDR, `mem_wdata_o`=0;
- `busy_o`=0, `done_o`=0, `chk_o`=0, `core_reset_o`=1;
- `loaded`=0, byte_cnt=0, word count=0.

Verification
REQ-033 Start with len=2; stream bytes 13,00,00,00,93,00,10,00 with valid held high -> writes 0x00000013 @0x01000000, then 0x00100093 @0x01000004; `done_o` pulses 1 cycle; `chk_o`=0x90; `core_reset_o` falls after DONE.
REQ-034 Same stream with `byte_valid_i` toggling every other cycle -> identical writes and data; no byte accepted while valid=0.
REQ-035 Start with len=0 -> no `mem_we_o`; `done_o` pulses 1 cycle after start; `busy_o` stays 0.
REQ-036 `start_i` pulsed again during RECV with len=5 -> ignored; the session ends after the originally latched length.
REQ-037 Reset asserted after 2 bytes of word 1 -> all outputs at reset values; a new len=1 session writes its own word at BASE_ADDR.
REQ-038 BASE_ADDR=32'hFFFF_FFFC, len=2 -> second write goes to 0x00000000.
